// File: rtl/rib_wb_master_bridge.sv
// Bridges the tinyriscv RIB request port onto a Wishbone classic master cycle,
// stalling the core via rib_hold_o until the slave acks. Optional bus timeout: WB_TIMEOUT_EN.
module rib_wb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_core,
  input  logic                  rst_core,
  input  logic                  rib_req_i,
  input  logic                  rib_we_i,
  input  logic [ADDR_WIDTH-1:0] rib_addr_i,
  input  logic [DATA_WIDTH-1:0] rib_data_i,
  input  logic [3:0]            rib_sel_i,
  output logic [DATA_WIDTH-1:0] rib_data_o,
  output logic                  rib_hold_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i,
  output logic                  err_o
);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("rib_wb_master_bridge: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_timeout;

`ifdef WB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_err;

  // Counter sits at zero outside BUS, so it is clear on every BUS entry.
  always_ff @(posedge clk_core) begin
    if (rst_core || r_state != S_BUS) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign err_o     = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (rib_req_i) w_next = S_BUS;
      S_BUS:   if (wb_ack_i || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign rib_hold_o = !rst_core && ((r_state == S_IDLE && rib_req_i) || r_state == S_BUS);

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      rib_data_o <= '0;
`ifdef WB_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
    end else begin
`ifdef WB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (rib_req_i) begin
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            wb_we_o   <= rib_we_i;
            wb_sel_o  <= rib_sel_i;
            wb_addr_o <= rib_addr_i;
            wb_data_o <= rib_data_i;
          end
        end
        S_BUS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (wb_ack_i) begin
            if (!wb_we_o) rib_data_o <= wb_data_i;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
          end
`ifdef WB_TIMEOUT_EN
          else if (w_timeout) begin
            rib_data_o <= '0;
            r_err      <= 1'b1;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_wb_master_bridge.sv
// Directed testbench for rib_wb_master_bridge; timeout steps run only when WB_TIMEOUT_EN is defined.
module tb_rib_wb_master_bridge;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        rib_req_i;
  logic        rib_we_i;
  logic [31:0] rib_addr_i;
  logic [31:0] rib_data_i;
  logic [3:0]  rib_sel_i;
  logic [31:0] rib_data_o;
  logic        rib_hold_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  rib_wb_master_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .rib_req_i (rib_req_i),
    .rib_we_i  (rib_we_i),
    .rib_addr_i(rib_addr_i),
    .rib_data_i(rib_data_i),
    .rib_sel_i (rib_sel_i),
    .rib_data_o(rib_data_o),
    .rib_hold_o(rib_hold_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_addr_o (wb_addr_o),
    .wb_data_o (wb_data_o),
    .wb_data_i (wb_data_i),
    .wb_ack_i  (wb_ack_i),
    .err_o     (err_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after the falling edge; outputs checked 1ns later.
  task automatic next_cycle();
    @(negedge clk_core);
  endtask

  initial begin
    rst_core   = 1'b1;
    rib_req_i  = 1'b1;
    rib_we_i   = 1'b0;
    rib_addr_i = 32'h0000_0100;
    rib_data_i = '0;
    rib_sel_i  = 4'hF;
    wb_data_i  = '0;
    wb_ack_i   = 1'b0;

    // Reset values, hold masked even with a request pending
    next_cycle();
    next_cycle(); #1;
    chk("rst_cyc",   wb_cyc_o,   0);
    chk("rst_stb",   wb_stb_o,   0);
    chk("rst_sel",   wb_sel_o,   0);
    chk("rst_addr",  wb_addr_o,  0);
    chk("rst_rdata", rib_data_o, 0);
    chk("rst_hold",  rib_hold_o, 0);
    chk("rst_err",   err_o,      0);
    rst_core  = 1'b0;
    rib_req_i = 1'b0;

    // Read, zero-wait slave
    next_cycle();
    rib_req_i = 1'b1; rib_we_i = 1'b0; rib_addr_i = 32'h0000_0100; rib_sel_i = 4'hF; #1;
    chk("t1_req_hold", rib_hold_o, 1);
    chk("t1_req_cyc",  wb_cyc_o,   0);
    next_cycle();
    rib_req_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'hDEAD_BEEF; #1;
    chk("t1_bus_cyc",  wb_cyc_o,   1);
    chk("t1_bus_stb",  wb_stb_o,   1);
    chk("t1_bus_we",   wb_we_o,    0);
    chk("t1_bus_addr", wb_addr_o,  32'h0000_0100);
    chk("t1_bus_hold", rib_hold_o, 1);
    next_cycle();
    wb_ack_i = 1'b0; #1;
    chk("t1_resp_cyc",   wb_cyc_o,   0);
    chk("t1_resp_stb",   wb_stb_o,   0);
    chk("t1_resp_hold",  rib_hold_o, 0);
    chk("t1_resp_rdata", rib_data_o, 32'hDEAD_BEEF);
    chk("t1_resp_err",   err_o,      0);
    next_cycle(); #1;
    chk("t1_idle_cyc",  wb_cyc_o,   0);
    chk("t1_idle_hold", rib_hold_o, 0);

    // Write, three wait states; RIB inputs scrambled during BUS must not leak
    next_cycle();
    rib_req_i = 1'b1; rib_we_i = 1'b1; rib_addr_i = 32'h8000_0004;
    rib_data_i = 32'h1234_5678; rib_sel_i = 4'b0011; #1;
    chk("t2_req_hold", rib_hold_o, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rib_req_i = 1'b0; rib_we_i = 1'b0; rib_addr_i = 32'hFFFF_FFFF;
      rib_data_i = '0; rib_sel_i = 4'h0;
      wb_ack_i = (i == 3); wb_data_i = 32'hCAFE_F00D; #1;
      chk("t2_bus_cyc",  wb_cyc_o,   1);
      chk("t2_bus_we",   wb_we_o,    1);
      chk("t2_bus_addr", wb_addr_o,  32'h8000_0004);
      chk("t2_bus_data", wb_data_o,  32'h1234_5678);
      chk("t2_bus_sel",  wb_sel_o,   4'b0011);
      chk("t2_bus_hold", rib_hold_o, 1);
    end
    next_cycle();
    wb_ack_i = 1'b0; #1;
    chk("t2_resp_cyc",   wb_cyc_o,   0);
    chk("t2_resp_we",    wb_we_o,    0);
    chk("t2_resp_sel",   wb_sel_o,   0);
    chk("t2_resp_hold",  rib_hold_o, 0);
    chk("t2_resp_rdata", rib_data_o, 32'hDEAD_BEEF);
    chk("t2_resp_addr",  wb_addr_o,  32'h8000_0004);
    chk("t2_resp_wdata", wb_data_o,  32'h1234_5678);

    // Back-to-back reads with req held high
    next_cycle();
    rib_req_i = 1'b1; rib_we_i = 1'b0; rib_addr_i = 32'h0; rib_sel_i = 4'hF; #1;
    chk("t3_req0_hold", rib_hold_o, 1);
    next_cycle();
    wb_ack_i = 1'b1; wb_data_i = 32'h1111_1111; #1;
    chk("t3_bus0_cyc",  wb_cyc_o,  1);
    chk("t3_bus0_addr", wb_addr_o, 32'h0);
    next_cycle();
    wb_ack_i = 1'b0; #1;
    chk("t3_resp0_hold",  rib_hold_o, 0);
    chk("t3_resp0_cyc",   wb_cyc_o,   0);
    chk("t3_resp0_rdata", rib_data_o, 32'h1111_1111);
    rib_addr_i = 32'h4;
    next_cycle(); #1;
    chk("t3_req1_hold", rib_hold_o, 1);
    chk("t3_req1_cyc",  wb_cyc_o,   0);
    next_cycle();
    wb_ack_i = 1'b1; wb_data_i = 32'h2222_2222; #1;
    chk("t3_bus1_cyc",  wb_cyc_o,  1);
    chk("t3_bus1_addr", wb_addr_o, 32'h4);
    next_cycle();
    wb_ack_i = 1'b0; rib_req_i = 1'b0; #1;
    chk("t3_resp1_rdata", rib_data_o, 32'h2222_2222);
    chk("t3_resp1_hold",  rib_hold_o, 0);

`ifdef WB_TIMEOUT_EN
    // Slave never acks: abort after four BUS cycles
    next_cycle();
    rib_req_i = 1'b1; rib_addr_i = 32'h200; #1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rib_req_i = 1'b0; #1;
      chk("t6_bus_cyc", wb_cyc_o, 1);
      chk("t6_bus_err", err_o,    0);
    end
    next_cycle(); #1;
    chk("t6_to_cyc",   wb_cyc_o,   0);
    chk("t6_to_err",   err_o,      1);
    chk("t6_to_rdata", rib_data_o, 0);
    chk("t6_to_hold",  rib_hold_o, 0);
    next_cycle(); #1;
    chk("t6_after_err", err_o, 0);

    // Ack coinciding with the timeout cycle completes normally
    rib_req_i = 1'b1; rib_addr_i = 32'h204; #1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rib_req_i = 1'b0; wb_ack_i = (i == 3); wb_data_i = 32'h3333_3333; #1;
      chk("t7_bus_cyc", wb_cyc_o, 1);
    end
    next_cycle();
    wb_ack_i = 1'b0; #1;
    chk("t7_resp_err",   err_o,      0);
    chk("t7_resp_rdata", rib_data_o, 32'h3333_3333);
`endif

    // Reset asserted in the second BUS cycle
    next_cycle();
    rib_req_i = 1'b1; rib_we_i = 1'b0; rib_addr_i = 32'h40; #1;
    next_cycle();
    rib_req_i = 1'b0; #1;
    chk("t4_bus1_cyc", wb_cyc_o, 1);
    next_cycle(); #1;
    chk("t4_bus2_cyc", wb_cyc_o, 1);
    rst_core = 1'b1;
    next_cycle(); #1;
    chk("t4_rst_cyc",  wb_cyc_o,   0);
    chk("t4_rst_stb",  wb_stb_o,   0);
    chk("t4_rst_hold", rib_hold_o, 0);
    rst_core = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h0000_0BAD;
    next_cycle(); #1;
    chk("t4_late_ack_cyc",   wb_cyc_o,   0);
    chk("t4_late_ack_hold",  rib_hold_o, 0);
    chk("t4_late_ack_rdata", rib_data_o, 0);

    // Spurious ack in IDLE with no request
    wb_data_i = 32'h0000_0055;
    next_cycle(); #1;
    chk("t5_spur_rdata", rib_data_o, 0);
    chk("t5_spur_cyc",   wb_cyc_o,   0);
    chk("t5_spur_hold",  rib_hold_o, 0);
    chk("t5_spur_err",   err_o,      0);
    wb_ack_i = 1'b0;

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
